// File: rtl/seg_pkg.sv
// seg_pkg: shared display definitions for the clock2 display path.
//   - segment pattern type and bit order {g,f,e,d,c,b,a} (bit 0 = a)
//   - SEG_ZERO / SEG_BLANK patterns
//   - digit index constants, 5 = hour-high (leftmost) .. 0 = second-low
//   - debug view of the scan timer state
package seg_pkg;

    localparam int SEG_W      = 7;
    localparam int NUM_DIGITS = 6;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [2:0]       digit_t;

    // Segment bit positions inside a seg_t.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam seg_t SEG_ZERO  = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h00;

    localparam digit_t DIG_HRH  = 3'd5;
    localparam digit_t DIG_HRL  = 3'd4;
    localparam digit_t DIG_MINH = 3'd3;
    localparam digit_t DIG_MINL = 3'd2;
    localparam digit_t DIG_SECH = 3'd1;
    localparam digit_t DIG_SECL = 3'd0;

    // Observable scan state (slot zero-extended to a fixed width).
    typedef struct packed {
        logic       active;
        digit_t     digit;
        logic [7:0] slot;
        logic       blink_phase;
    } scan_dbg_t;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(digit_t d);
        return NUM_DIGITS'(1) << d;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: the six digit segment patterns coming from clock2.
//   master : producer side (clock2), drives the patterns
//   slave  : consumer side (seg_scan_mux), reads the patterns
// Patterns are active-high {g,f,e,d,c,b,a}. There is no handshake: the
// producer holds a level and the consumer samples it once per frame.
interface seg_scan_mux_if;
    import seg_pkg::*;

    seg_t hrhigh_i;
    seg_t hrlow_i;
    seg_t minhigh_i;
    seg_t minlow_i;
    seg_t sechigh_i;
    seg_t seclow_i;

    modport master (
        output hrhigh_i, hrlow_i, minhigh_i, minlow_i, sechigh_i, seclow_i
    );

    modport slave (
        input  hrhigh_i, hrlow_i, minhigh_i, minlow_i, sechigh_i, seclow_i
    );

endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot/digit scan counters plus frame counter and blink phase.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   en_i                 display enable; low parks the scan and holds blink
//   slot_q, digit_q      current slot (0..SCAN_DIV-1) and digit (5..0)
//   active_q             scan running (cleared by reset or en_i low)
//   frame_pulse          registered: this cycle is a snapshot cycle
//   blink_phase          registered: 1 = on (digits shown, colon lit)
//   slot_d .. phase_d    next-state values, so the caller can register its
//                        outputs in the same edge as the counters and keep
//                        them aligned with slot_q/digit_q
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 2,
    localparam int SLOT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic [SLOT_W-1:0] slot_q,
    output digit_t            digit_q,
    output logic              active_q,
    output logic              frame_pulse,
    output logic              blink_phase,
    output logic [SLOT_W-1:0] slot_d,
    output digit_t            digit_d,
    output logic              active_d,
    output logic              frame_d,
    output logic              phase_d
);

    localparam int                FCNT_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [FCNT_W-1:0] FCNT_TOP  = FCNT_W'(BLINK_FRAMES);

    // Counts frames since the last phase toggle. It starts at 0 after reset
    // so that the first BLINK_FRAMES frames run with the phase on.
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    always_comb begin
        active_d = active_q;
        slot_d   = slot_q;
        digit_d  = digit_q;
        frame_d  = 1'b0;
        fcnt_d   = fcnt_q;
        phase_d  = blink_phase;

        if (!en_i) begin
            active_d = 1'b0;
            slot_d   = '0;
            digit_d  = DIG_HRH;
        end else if (!active_q) begin
            // First enabled cycle is always a fresh frame at digit 5.
            active_d = 1'b1;
            slot_d   = '0;
            digit_d  = DIG_HRH;
            frame_d  = 1'b1;
        end else if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            if (digit_q == DIG_SECL) begin
                digit_d = DIG_HRH;
                frame_d = 1'b1;
            end else begin
                digit_d = digit_q - 3'd1;
            end
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end

        // Blink counter only moves on frames, so it holds while disabled.
        if (frame_d) begin
            if (fcnt_q == FCNT_TOP) begin
                phase_d = ~blink_phase;
                fcnt_d  = FCNT_W'(1);
            end else begin
                fcnt_d  = fcnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q      <= '0;
            digit_q     <= '0;
            active_q    <= 1'b0;
            frame_pulse <= 1'b0;
            fcnt_q      <= '0;
            blink_phase <= 1'b1;
        end else begin
            slot_q      <= slot_d;
            digit_q     <= digit_d;
            active_q    <= active_d;
            frame_pulse <= frame_d;
            fcnt_q      <= fcnt_d;
            blink_phase <= phase_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes six 7-segment digits onto one segment bus.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   en_i            display enable
//   lzb_i           blank hour-high digit when its snapshot shows '0'
//   blink_i         per-digit blink mask (bit5 = hour-high), sampled live
//   dig_if          six segment patterns from clock2 (slave modport)
//   seg_o, dp_o     shared segment bus and colon (decimal point)
//   an_o            one-hot digit enables, bit5 = leftmost
//   frame_o         one-cycle pulse when a new snapshot is taken
//   dbg_o           scan timer state for observation
// seg_o/dp_o/an_o are active-low when ACTIVE_LOW = 1; all internal logic is
// active-high and inverted only at the output registers.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEAD         = 1,
    parameter int BLINK_FRAMES = 2,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  lzb_i,
    input  logic [NUM_DIGITS-1:0] blink_i,
    seg_scan_mux_if.slave         dig_if,
    output seg_t                  seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic                  frame_o,
    output scan_dbg_t             dbg_o
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SLOT_W-1:0] slot_q, slot_d;
    digit_t            digit_q, digit_d;
    logic              active_q, active_d;
    logic              frame_pulse, frame_d;
    logic              blink_phase, phase_d;

    seg_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .slot_q      (slot_q),
        .digit_q     (digit_q),
        .active_q    (active_q),
        .frame_pulse (frame_pulse),
        .blink_phase (blink_phase),
        .slot_d      (slot_d),
        .digit_d     (digit_d),
        .active_d    (active_d),
        .frame_d     (frame_d),
        .phase_d     (phase_d)
    );

    // Snapshot: element [5] is hour-high.
    logic [NUM_DIGITS-1:0][SEG_W-1:0] snap_q, snap_d;

    logic [NUM_DIGITS-1:0] an_d, an_q;
    seg_t                  seg_d, seg_q, cur_seg;
    logic                  dp_d, dp_q;
    logic                  lit;

    always_comb begin
        snap_d = snap_q;
        if (frame_d) begin
            snap_d = {dig_if.hrhigh_i, dig_if.hrlow_i,  dig_if.minhigh_i,
                      dig_if.minlow_i, dig_if.sechigh_i, dig_if.seclow_i};
        end
    end

    // Outputs are computed from the next counter state and registered on the
    // same edge as the counters, so an_o/seg_o line up with slot_q/digit_q.
    always_comb begin
        lit     = active_d && (int'(slot_d) >= DEAD);
        cur_seg = snap_d[digit_d];

        if (lzb_i && (digit_d == DIG_HRH) && (cur_seg == SEG_ZERO)) begin
            cur_seg = SEG_BLANK;
        end
        if (!phase_d && blink_i[digit_d]) begin
            cur_seg = SEG_BLANK;
        end

        an_d  = '0;
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (lit) begin
            an_d  = digit_onehot(digit_d);
            seg_d = cur_seg;
            // Colon dots sit after hour-low and minute-low.
            dp_d  = phase_d && ((digit_d == DIG_HRL) || (digit_d == DIG_MINL));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q <= '0;
            an_q   <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q  <= {SEG_W{ACTIVE_LOW}};
            dp_q   <= ACTIVE_LOW;
        end else begin
            snap_q <= snap_d;
            an_q   <= an_d  ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg_q  <= seg_d ^ {SEG_W{ACTIVE_LOW}};
            dp_q   <= dp_d  ^ ACTIVE_LOW;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_pulse;

    always_comb begin
        dbg_o             = '0;
        dbg_o.active      = active_q;
        dbg_o.digit       = digit_q;
        dbg_o.slot        = 8'(slot_q);
        dbg_o.blink_phase = blink_phase;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Downstream display stage for the `clock2` time-of-day counter. Takes the six 7-segment patterns `clock2` produces (hours, minutes, seconds, high/low digits) and time-multiplexes them onto one shared segment bus with one-hot digit enables. Adds the following:
- frame-coherent snapshotting;
- anti-ghosting dead time;
- optional leading-zero blanking of the hour-high digit;
- per-digit blink;
- a colon (decimal-point) indicator.

## Interface
Parameters:
- SCAN_DIV, 4, clocks per digit slot; must be ≥ DEAD+1
- DEAD, 1, clocks at start of each slot with all anodes off
- BLINK_FRAMES, 2, frames per blink half-period; must be ≥ 1
- ACTIVE_LOW, 1, 1: seg_o, dp_o, an_o driven active-low; 0: active-high

Ports:
- clk_i  in  1  system clock, single clock domain
- rst_ni  in  1  reset, asynchronous assert, active-low
- en_i  in  1  display enable
- lzb_i  in  1  blank hour-high digit when it shows '0'
- blink_i  in  6  per-digit blink mask, bit5 = hour-high … bit0 = sec-low
- hrhigh_i, hrlow_i, minhigh_i, minlow_i, sechigh_i, seclow_i  in  7 each  segment patterns {g,f,e,d,c,b,a}, active-high, from clock2
- seg_o  out  7  shared segment bus
- dp_o  out  1  decimal point (colon)
- an_o  out  6  digit enables, bit5 = leftmost (hour-high)
- frame_o  out  1  one-cycle pulse when a new snapshot is taken

## Operation
- Digit index d: 5 = hrhigh, 4 = hrlow, 3 = minhigh, 2 = minlow, 1 = sechigh, 0 = seclow. Scan order is 5→0, then repeats.
- Slot counter counts 0..SCAN_DIV-1 per digit. Digit counter counts 5..0.
  - Cycles 0..DEAD-1 of a slot: all anodes inactive, seg/dp inactive.
  - Cycles DEAD..SCAN_DIV-1: an_o[d] active; seg_o = snapshot[d] after the masking rules below.
- Snapshot: all six inputs are registered in the cycle where slot = 0 and d = 5. frame_o pulses in that same cycle. Inputs changing mid-frame never affect the current frame.
- Leading-zero blank: applies when lzb_i = 1 and snapshot[5] == SEG_ZERO (7'h3F). Digit 5 then shows SEG_BLANK; its anode still cycles.
- Blink:
  - The frame counter toggles blink_phase every BLINK_FRAMES frames, at the frame_o cycle.
  - While blink_phase = off, any digit d with blink_i[d] = 1 shows SEG_BLANK.
  - blink_i is sampled live, not snapshotted.
- Colon: dp active on digits 4 and 2 while blink_phase = on. Inactive otherwise.
- en_i = 0:
  - an_o, seg_o, dp_o inactive.
  - Slot and digit counters reset to slot 0, d = 5. No frame_o.
  - Blink counter holds.
- Rising en_i: the first active cycle is the slot 0, d = 5 snapshot cycle, with frame_o = 1.
- Polarity: ACTIVE_LOW inverts seg_o, dp_o and an_o at the output only. Internal logic is active-high.

## Timing
- All outputs are registered.
- Values during reset, and held until the first clock edge after rst_ni deasserts:
  - an_o, seg_o, dp_o at inactive level (all 1s if ACTIVE_LOW);
  - frame_o = 0;
  - counters and snapshot at 0;
  - blink_phase = on.
- First cycle after reset with en_i = 1 is the snapshot cycle (frame_o = 1).
- Frame length = 6·SCAN_DIV clocks. Blink period = 2·BLINK_FRAMES frames.
- Output latency: an_o/seg_o reflect the counter state of the same cycle (one register stage from counters). The snapshot-to-display delay is DEAD cycles for digit 5.
- Digit wrap: after d = 0 at slot SCAN_DIV-1, the next cycle is d = 5, slot 0, a new snapshot.
- Reset mid-frame: immediate asynchronous return to reset values; no partial-slot output.
- en_i falling mid-slot: outputs inactive on the next edge.

## Structure
- Package seg_pkg holds:
  - SEG_ZERO = 7'h3F and SEG_BLANK = 7'h00;
  - digit index constants DIG_HRH..DIG_SECL;
  - the segment bit-order definition. clock2 shares these.
- One sub-module, seg_scan_timer, holds the slot/digit counters and the frame counter/blink phase. It outputs slot_q, digit_q, frame_pulse and blink_phase.
- Top level holds the snapshot, masking, polarity and output registers.

## Test plan
All with SCAN_DIV = 4, DEAD = 1, BLINK_FRAMES = 2, ACTIVE_LOW = 1 unless stated.
- Reset/enable: hold rst_ni = 0 → an_o = 6'h3F, seg_o = 7'h7F, dp_o = 1. Release with en_i = 1 → frame_o pulses at first edge; an_o = 6'b011111 on cycles 1–3; frame_o repeats every 24 clocks.
- Snapshot coherence: inputs show 12:59:59 patterns; change minlow_i to '0' at cycle 10 → remainder of frame still shows '9' on digit 2; new value appears from the next frame.
- Leading zero: hrhigh_i = 7'h3F, lzb_i = 1 → digit 5 slot drives seg_o = 7'h7F with an_o[5] low. With lzb_i = 0 → seg_o = ~7'h3F.
- Blink/colon: blink_i = 6'b001100 → minute digits blank in frames 2–3, 6–7, …. dp_o low only on digits 4 and 2 in frames 0–1, 4–5.
- Disable mid-frame: drop en_i at cycle 13 → outputs inactive next edge. Re-raise → frame_o pulse, scan restarts at digit 5.
- Polarity: ACTIVE_LOW = 0 with seclow_i = 7'h06 → during digit 0 active cycles, an_o = 6'b000001, seg_o = 7'h06.
